// File: rtl/uart_rx_buf_pkg.sv
// Shared types and default constants for the buffered UART receiver.
// The optional parity stage is enabled by defining UART_RX_PARITY_EN.
package uart_rx_buf_pkg;

    localparam int unsigned DEF_CLKS_PER_BIT = 54;
    localparam int unsigned DEF_FIFO_DEPTH   = 4;
    localparam int unsigned DATA_W           = 8;
    localparam int unsigned BIT_CNT_W        = 3;

    typedef logic [DATA_W-1:0] rx_byte_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } rx_state_t;

    // Even parity: the parity bit that makes the total count of ones even.
    function automatic logic even_parity(input rx_byte_t b);
        return ^b;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous byte FIFO with a registered head word, so the oldest entry
// is presented directly from a flop whenever the buffer is non-empty.
module uart_rx_fifo
    import uart_rx_buf_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_FIFO_DEPTH,
    parameter int unsigned WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             valid,
    output logic             full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic             rd_en_c;
    logic             wr_en_c;
    logic [PTR_W-1:0] rd_ptr_n_c;
    logic [CNT_W-1:0] count_n_c;

    // A full buffer still accepts a write when the head leaves in the same cycle.
    always_comb begin
        rd_en_c    = pop && (count != '0);
        wr_en_c    = push && (!full || rd_en_c);
        rd_ptr_n_c = rd_ptr + PTR_W'(rd_en_c);
        count_n_c  = count + CNT_W'(wr_en_c) - CNT_W'(rd_en_c);
    end

    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Head register looks ahead: bypass the write when it becomes the new head.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head   <= '0;
            valid  <= 1'b0;
            full   <= 1'b0;
        end else begin
            if (wr_en_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr <= rd_ptr_n_c;
            count  <= count_n_c;
            valid  <= (count_n_c != '0);
            full   <= (count_n_c == CNT_W'(DEPTH));
            if (wr_en_c && (wr_ptr == rd_ptr_n_c)) begin
                head <= push_data;
            end else begin
                head <= mem[rd_ptr_n_c];
            end
        end
    end

endmodule

// File: rtl/uart_rx_buf.sv
// UART receiver (8 data bits, LSB first, 1 stop) feeding a small byte buffer.
// Define UART_RX_PARITY_EN to expect an even parity bit before the stop bit.
module uart_rx_buf
    import uart_rx_buf_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int unsigned FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic        frame_err,
    output logic        overrun,
    output logic        parity_err
);

    localparam int unsigned BAUD_W   = $clog2(CLKS_PER_BIT);
    localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
    localparam int unsigned BAUD_MAX = CLKS_PER_BIT - 1;
    localparam int unsigned BIT_LAST = DATA_W - 1;

    logic                 rx_meta;
    logic                 rx_sync;
    logic                 rx_prev;
    rx_state_t            state;
    logic [BAUD_W-1:0]    baud_cnt;
    logic [BIT_CNT_W-1:0] bit_cnt;
    rx_byte_t             shift;
    logic                 fifo_full;

    logic                 baud_done_c;
    logic                 half_done_c;
    logic                 push_c;
    logic                 pop_c;

`ifdef UART_RX_PARITY_EN
    logic                 par_bad;
`endif

    // Two-flop synchronizer plus the stored previous sample for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_comb begin
        baud_done_c = (baud_cnt == BAUD_W'(BAUD_MAX));
        half_done_c = (baud_cnt == BAUD_W'(HALF_BIT));
        pop_c       = rd_valid && rd_ready;
        push_c      = (state == ST_STOP) && baud_done_c && rx_sync;
`ifdef UART_RX_PARITY_EN
        if (par_bad) begin
            push_c = 1'b0;
        end
`endif
    end

    // Frame sequencer; error pulses are registered on the stop-bit sample edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            frame_err <= 1'b0;
            overrun   <= push_c && fifo_full && !pop_c;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        state    <= ST_START;
                        baud_cnt <= '0;
                    end
                end
                ST_START: begin
                    if (half_done_c) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= rx_sync ? ST_IDLE : ST_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                ST_DATA: begin
                    if (baud_done_c) begin
                        baud_cnt <= '0;
                        shift    <= {rx_sync, shift[DATA_W-1:1]};
                        if (bit_cnt == BIT_CNT_W'(BIT_LAST)) begin
                            bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                            state   <= ST_PARITY;
`else
                            state   <= ST_STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (baud_done_c) begin
                        baud_cnt <= '0;
                        par_bad  <= (rx_sync != even_parity(shift));
                        state    <= ST_STOP;
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
`endif
                ST_STOP: begin
                    if (baud_done_c) begin
                        baud_cnt  <= '0;
                        state     <= ST_IDLE;
                        frame_err <= !rx_sync;
`ifdef UART_RX_PARITY_EN
                        parity_err <= par_bad;
                        par_bad    <= 1'b0;
`endif
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                end
            endcase
        end
    end

`ifndef UART_RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_c),
        .push_data (shift),
        .pop       (pop_c),
        .head      (rd_data),
        .valid     (rd_valid),
        .full      (fifo_full)
    );

endmodule

// File: tb/tb_uart_rx_buf.sv
// Self-checking bench for uart_rx_buf: frame-level model with a byte queue,
// checked every cycle, plus literal expectations on the received byte stream.
`timescale 1ns/1ps
module tb_uart_rx_buf;

    localparam int unsigned CPB   = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned HALF  = CPB / 2;
`ifdef UART_RX_PARITY_EN
    localparam int unsigned NBITS = 10;
`else
    localparam int unsigned NBITS = 9;
`endif
    // Edge of stop-bit sample, counted from the edge the start bit is driven after:
    // 2 sync flops + edge detect, half a bit, then NBITS full bit periods.
    localparam int unsigned STOP_OFS = 3 + HALF + 1 + NBITS * CPB;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       rd_ready;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;

    uart_rx_buf #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         t;
        logic [7:0] b;
        bit         stop_ok;
        bit         par_ok;
    } frame_t;

    frame_t     pend[$];
    logic [7:0] mq[$];
    logic [7:0] log_q[$];
    int         cyc = 0;
    int         errors = 0;
    int         checks = 0;
    int         n_fe = 0;
    int         n_ov = 0;
    int         n_pe = 0;
    bit         pop_pending = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_log(input string name, input int n, input logic [63:0] exp);
        logic [63:0] e;
        e = exp;
        chk({name, "_len"}, log_q.size(), n);
        for (int i = 0; i < n; i++) begin
            chk(name, (i < log_q.size()) ? int'(log_q[i]) : -1, int'(e[8*i +: 8]));
        end
    endtask

    // Model: byte queue updated by pops and completed frames, compared every cycle.
    always @(negedge clk) begin
        bit     exp_fe;
        bit     exp_ov;
        bit     exp_pe;
        bit     was_full;
        frame_t f;
        if (rst) begin
            mq.delete();
            pop_pending = 1'b0;
        end else begin
            exp_fe   = 1'b0;
            exp_ov   = 1'b0;
            exp_pe   = 1'b0;
            was_full = (mq.size() == DEPTH);
            if (pop_pending) void'(mq.pop_front());
            if (pend.size() > 0 && pend[0].t == cyc) begin
                f = pend.pop_front();
                if (!f.stop_ok) exp_fe = 1'b1;
                if (!f.par_ok) exp_pe = 1'b1;
                if (f.stop_ok && f.par_ok) begin
                    if (was_full && !pop_pending) exp_ov = 1'b1;
                    else mq.push_back(f.b);
                end
            end
            chk("rd_valid", rd_valid, mq.size() != 0);
            if (mq.size() != 0) chk("rd_data", rd_data, mq[0]);
            chk("frame_err", frame_err, exp_fe);
            chk("overrun", overrun, exp_ov);
            chk("parity_err", parity_err, exp_pe);
            if (frame_err) n_fe++;
            if (overrun) n_ov++;
            if (parity_err) n_pe++;
            pop_pending = (mq.size() != 0) && rd_ready;
            if (rd_valid && rd_ready) log_q.push_back(rd_data);
        end
    end

    // Drive one frame; abort_bit >= 0 pulses rst at the start of that bit index.
    task automatic send_frame(input logic [7:0] b, input bit stop, input bit par_bad,
                              input int abort_bit, output int t_stop);
        logic [10:0] seq;
        frame_t      f;
        seq = '1;
        seq[0] = 1'b0;
        for (int i = 0; i < 8; i++) seq[1+i] = b[i];
`ifdef UART_RX_PARITY_EN
        seq[9] = (^b) ^ par_bad;
`endif
        seq[NBITS] = stop;
        @(posedge clk); #1;
        f.t = cyc + STOP_OFS;
        f.b = b;
        f.stop_ok = stop;
        f.par_ok = !par_bad;
        t_stop = f.t;
        if (abort_bit < 0) pend.push_back(f);
        for (int i = 0; i <= NBITS; i++) begin
            if (i == abort_bit) begin
                rst = 1'b1;
                pend.delete();
                @(posedge clk); #1;
                rst = 1'b0;
            end
            rx = seq[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
        rx = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int t;
        int fe0;
        int ov0;
        int pe0;
        rst = 1'b1;
        rx = 1'b1;
        rd_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_parity_err", parity_err, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(4);

        // Two clean bytes, consumer always ready
        rd_ready = 1'b1;
        log_q.delete();
        fe0 = n_fe;
        send_frame(8'hA5, 1'b1, 1'b0, -1, t);
        send_frame(8'h3C, 1'b1, 1'b0, -1, t);
        idle(8);
        chk_log("a5_3c", 2, 64'h3CA5);
        chk("a5_3c_fe", n_fe - fe0, 0);

        // One-cycle low glitch on idle line
        log_q.delete();
        fe0 = n_fe;
        ov0 = n_ov;
        @(posedge clk); #1; rx = 1'b0;
        @(posedge clk); #1; rx = 1'b1;
        idle(20);
        chk("glitch_log", log_q.size(), 0);
        chk("glitch_fe", n_fe - fe0, 0);
        chk("glitch_ov", n_ov - ov0, 0);

        // Bad stop bit, then a good byte
        log_q.delete();
        fe0 = n_fe;
        send_frame(8'h55, 1'b0, 1'b0, -1, t);
        idle(4);
        chk("stop_bad_fe", n_fe - fe0, 1);
        chk("stop_bad_log", log_q.size(), 0);
        send_frame(8'h12, 1'b1, 1'b0, -1, t);
        idle(8);
        chk_log("after_fe", 1, 64'h12);

        // Five bytes into a depth-4 buffer with no consumer
        rd_ready = 1'b0;
        log_q.delete();
        ov0 = n_ov;
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0, -1, t);
        idle(4);
        chk("overrun_cnt", n_ov - ov0, 1);
        rd_ready = 1'b1;
        idle(10);
        chk_log("drain_1_4", 4, 64'h04030201);

        // Full buffer with a pop in the very cycle 0x77 is pushed
        rd_ready = 1'b0;
        log_q.delete();
        ov0 = n_ov;
        for (int i = 0; i < 4; i++) send_frame(8'h11 + 8'(i), 1'b1, 1'b0, -1, t);
        send_frame(8'h77, 1'b1, 1'b0, -1, t);
        while (cyc < t - 1) begin
            @(posedge clk); #1;
        end
        rd_ready = 1'b1;
        @(posedge clk); #1;
        rd_ready = 1'b0;
        idle(3);
        rd_ready = 1'b1;
        idle(10);
        chk("full_pop_ov", n_ov - ov0, 0);
        chk_log("full_pop", 5, 64'h7714131211);

        // Reset in the middle of 0xFF data bits, then 0x81
        log_q.delete();
        send_frame(8'hFF, 1'b1, 1'b0, 4, t);
        idle(5);
        send_frame(8'h81, 1'b1, 1'b0, -1, t);
        idle(10);
        chk_log("abort", 1, 64'h81);

`ifdef UART_RX_PARITY_EN
        // Odd parity on 0x81 must be rejected
        log_q.delete();
        pe0 = n_pe;
        send_frame(8'h81, 1'b1, 1'b1, -1, t);
        idle(10);
        chk("parity_cnt", n_pe - pe0, 1);
        chk("parity_log", log_q.size(), 0);
`else
        pe0 = n_pe;
        chk("parity_none", pe0, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_buf.md
UART_RX_BUF -- requirements
Module: uart_rx_buf

Interface
REQ-001 Parameter CLKS_PER_BIT, default 54, sets clk cycles per UART bit (legal 4..1023).
REQ-002 Parameter FIFO_DEPTH, default 4, sets received-byte buffer entries (power of two, 2..16).
REQ-003 clk  input  1  single clock; all flops on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 rx  input  1  asynchronous serial line; idle high; 8 data bits, LSB first, 1 stop bit.
REQ-006 rd_data  output  8  oldest buffered byte; valid only while rd_valid=1.
REQ-007 rd_valid  output  1  buffer not empty.
REQ-008 rd_ready  input  1  consumer accepts rd_data this cycle.
REQ-009 frame_err  output  1  one-cycle pulse on stop bit sampled low.
REQ-010 overrun  output  1  one-cycle pulse when a good byte arrives with buffer full and no pop.
REQ-011 parity_err  output  1  one-cycle pulse on parity mismatch; constant 0 without UART_RX_PARITY_EN.

Function
REQ-012 rx SHALL pass a 2-flop synchronizer (reset value 1) before any use; rx-to-state latency 2 cycles.
REQ-013 FSM states: IDLE, START, DATA, PARITY, STOP; one bit counter (0..7) and one baud counter (0..CLKS_PER_BIT-1).
REQ-014 IDLE->START on synchronized falling edge (previous sample 1, current 0); baud counter cleared.
REQ-015 START: sample at CLKS_PER_BIT/2 (integer divide); sample 1 -> IDLE (glitch, no pulse); sample 0 -> DATA, baud counter cleared.
REQ-016 DATA: sample each bit after CLKS_PER_BIT cycles, shift into bit 7 of shift register (LSB first); after bit 7 -> PARITY if UART_RX_PARITY_EN, else STOP.
REQ-017 STOP: sample after CLKS_PER_BIT cycles; 1 -> push byte (unless parity failed); 0 -> frame_err pulse, byte discarded; then IDLE in the same cycle.
REQ-018 Push and error pulses SHALL occur in the cycle after the stop-bit sample; rd_valid rises that same cycle if buffer was empty.
REQ-019 Pop when rd_valid && rd_ready; rd_data is registered from the buffer head and updates the cycle after a pop.
REQ-020 Simultaneous push and pop: both honoured; count unchanged; full+push+pop SHALL NOT raise overrun.
REQ-021 Full without pop: incoming byte dropped, overrun pulses, buffer contents untouched.
REQ-022 rd_ready while empty: no effect; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-023 A falling edge during STOP processing SHALL NOT be lost: IDLE edge detect uses stored previous sample.

Reset
REQ-024 rst SHALL asynchronously force: FSM IDLE, counters 0, synchronizer flops 1, FIFO empty, rd_valid 0, rd_data 0, all pulses 0.
REQ-025 rst mid-frame SHALL abort the frame; no partial byte pushed; reception resumes on next falling edge after release.

Configuration
REQ-026 Macro UART_RX_PARITY_EN: defined -> even parity bit expected between bit 7 and stop; mismatch -> parity_err pulse, byte discarded even if stop good.
REQ-027 Undefined -> PARITY state and parity logic absent; parity_err tied 0; frame is 10 bits.

Structure
REQ-028 Shared package holds FSM state enum and default constants (CLKS_PER_BIT default, FIFO_DEPTH default).
REQ-029 One sub-module, uart_rx_fifo (synchronous FIFO with push/pop/full/empty), instantiated once.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-030 Send 0xA5 then 0x3C, rd_ready=1 -> rd_data 0xA5 then 0x3C, no error pulses, rd_valid one cycle after each stop sample.
REQ-031 Low glitch of 1 cycle on idle rx -> FSM returns to IDLE, rd_valid stays 0, no pulses.
REQ-032 Send 0x55 with stop bit 0 -> frame_err pulses once, buffer stays empty; next 0x12 received correctly.
REQ-033 rd_ready=0, send 5 bytes 0x01..0x05 -> overrun pulses once at byte 5; drain yields 0x01..0x04.
REQ-034 Full buffer, assert rd_ready in push cycle of 0x77 -> no overrun, drain order ends with 0x77.
REQ-035 rst pulse mid-DATA of 0xFF, then send 0x81 -> only 0x81 read; with UART_RX_PARITY_EN, 0x81 sent with odd parity -> parity_err pulse, nothing buffered.
